// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side fields, forwarding sources, stall controls and EX-side results.
// The stage itself is the slave; whoever drives the pipeline around it is the master.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [31:0] id_rf_rd0;
  logic [31:0] id_rf_rd1;
  logic        id_rf_we;
  logic        id_mem_read;
  logic [15:0] id_ctrl;

  logic        mem_rf_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wd;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;

  logic        hold;
  logic        flush;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rf_we;
  logic        ex_mem_read;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        id_stall;
  logic [31:0] bubble_cnt;

  modport slave (
    input  id_valid, id_pc, id_inst, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_rf_rd0, id_rf_rd1, id_rf_we,
           id_mem_read, id_ctrl,
           mem_rf_we, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd,
           hold, flush,
    output ex_valid, ex_pc, ex_inst, ex_imm, ex_rd, ex_rf_we, ex_mem_read,
           ex_ctrl, ex_op1, ex_op2, id_stall, bubble_cnt
  );

  modport master (
    output id_valid, id_pc, id_inst, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_rf_rd0, id_rf_rd1, id_rf_we,
           id_mem_read, id_ctrl,
           mem_rf_we, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd,
           hold, flush,
    input  ex_valid, ex_pc, ex_inst, ex_imm, ex_rd, ex_rf_we, ex_mem_read,
           ex_ctrl, ex_op1, ex_op2, id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and MEM/WB operand forwarding.
// One cycle ID->EX; hold freezes the stage, id_stall freezes PC and IF/ID upstream.
module id_ex_stage (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave stg
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        rf_we_q, rf_we_d;
  logic        mem_read_q, mem_read_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] bub_q, bub_d;

  logic load_use;

  assign load_use = valid_q & mem_read_q & (rd_q != 5'd0) & stg.id_valid &
                    ((stg.id_use_rs1 & (stg.id_rs1 == rd_q)) |
                     (stg.id_use_rs2 & (stg.id_rs2 == rd_q)));

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    rf_we_d    = rf_we_q;
    mem_read_d = mem_read_q;
    ctrl_d     = ctrl_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    bub_d      = bub_q;
    if (stg.flush) begin
      valid_d    = 1'b0;
      rf_we_d    = 1'b0;
      mem_read_d = 1'b0;
      ctrl_d     = 16'd0;
    end else if (stg.hold) begin
      // everything retained
    end else if (load_use) begin
      // bubble only kills side effects; data fields are meaningless while valid is low
      valid_d    = 1'b0;
      rf_we_d    = 1'b0;
      mem_read_d = 1'b0;
      ctrl_d     = 16'd0;
      bub_d      = (bub_q == 32'hFFFF_FFFF) ? bub_q : bub_q + 32'd1;
    end else begin
      valid_d    = stg.id_valid;
      pc_d       = stg.id_pc;
      inst_d     = stg.id_inst;
      imm_d      = stg.id_imm;
      rd_d       = stg.id_rd;
      rf_we_d    = stg.id_rf_we & stg.id_valid & (stg.id_rd != 5'd0);
      mem_read_d = stg.id_mem_read;
      ctrl_d     = stg.id_ctrl;
      rs1_d      = stg.id_rs1;
      rs2_d      = stg.id_rs2;
      op1_d      = stg.id_rf_rd0;
      op2_d      = stg.id_rf_rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
      imm_q      <= 32'd0;
      rd_q       <= 5'd0;
      rf_we_q    <= 1'b0;
      mem_read_q <= 1'b0;
      ctrl_q     <= 16'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      bub_q      <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      rf_we_q    <= rf_we_d;
      mem_read_q <= mem_read_d;
      ctrl_q     <= ctrl_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      bub_q      <= bub_d;
    end
  end

  // Forwarding is re-evaluated every cycle, so a held instruction still sees newer MEM/WB results.
  always_comb begin
    stg.ex_op1 = op1_q;
    if (stg.mem_rf_we && stg.mem_rd != 5'd0 && stg.mem_rd == rs1_q)
      stg.ex_op1 = stg.mem_wd;
    else if (stg.wb_rf_we && stg.wb_rd != 5'd0 && stg.wb_rd == rs1_q)
      stg.ex_op1 = stg.wb_wd;
  end

  always_comb begin
    stg.ex_op2 = op2_q;
    if (stg.mem_rf_we && stg.mem_rd != 5'd0 && stg.mem_rd == rs2_q)
      stg.ex_op2 = stg.mem_wd;
    else if (stg.wb_rf_we && stg.wb_rd != 5'd0 && stg.wb_rd == rs2_q)
      stg.ex_op2 = stg.wb_wd;
  end

  assign stg.id_stall    = (load_use & ~stg.flush) | stg.hold;
  assign stg.ex_valid    = valid_q;
  assign stg.ex_pc       = pc_q;
  assign stg.ex_inst     = inst_q;
  assign stg.ex_imm      = imm_q;
  assign stg.ex_rd       = rd_q;
  assign stg.ex_rf_we    = rf_we_q;
  assign stg.ex_mem_read = mem_read_q;
  assign stg.ex_ctrl     = ctrl_q;
  assign stg.bubble_cnt  = bub_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic, all checked against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .stg (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of what instruction currently sits in EX
  logic        m_valid, m_rf_we, m_mem_read;
  logic [31:0] m_pc, m_inst, m_imm, m_rd0, m_rd1, m_bub;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [15:0] m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] cap);
    if (src != 0 && bus.mem_rf_we && bus.mem_rd == src) return bus.mem_wd;
    if (src != 0 && bus.wb_rf_we && bus.wb_rd == src) return bus.wb_wd;
    return cap;
  endfunction

  function automatic logic model_hazard();
    if (!(m_valid && m_mem_read && m_rd != 0 && bus.id_valid)) return 1'b0;
    return (bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd);
  endfunction

  task automatic compare_model();
    chk("id_stall", 32'(bus.id_stall), 32'((model_hazard() && !bus.flush) || bus.hold));
    chk("bubble_cnt", bus.bubble_cnt, m_bub);
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("ex_rf_we", 32'(bus.ex_rf_we), 32'(m_rf_we));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m_mem_read));
    chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
    if (m_valid) begin
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("ex_inst", bus.ex_inst, m_inst);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
      chk("ex_op1", bus.ex_op1, fwd(m_rs1, m_rd0));
      chk("ex_op2", bus.ex_op2, fwd(m_rs2, m_rd1));
    end
  endtask

  task automatic kill_slot();
    m_valid = 0; m_rf_we = 0; m_mem_read = 0; m_ctrl = 0;
  endtask

  task automatic model_update();
    logic haz;
    haz = model_hazard();
    if (rst) begin
      kill_slot();
      m_pc = 0; m_inst = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_rd0 = 0; m_rd1 = 0; m_bub = 0;
    end else if (bus.flush) begin
      kill_slot();
    end else if (bus.hold) begin
      // slot frozen
    end else if (haz) begin
      kill_slot();
      if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    end else begin
      m_valid    = bus.id_valid;
      m_pc       = bus.id_pc;
      m_inst     = bus.id_inst;
      m_imm      = bus.id_imm;
      m_rd       = bus.id_rd;
      m_rf_we    = bus.id_rf_we && bus.id_valid && bus.id_rd != 0;
      m_mem_read = bus.id_mem_read;
      m_ctrl     = bus.id_ctrl;
      m_rs1      = bus.id_rs1;
      m_rs2      = bus.id_rs2;
      m_rd0      = bus.id_rf_rd0;
      m_rd1      = bus.id_rf_rd1;
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc();
    #1;
    compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_inst = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_rf_rd0 = 0; bus.id_rf_rd1 = 0;
    bus.id_rf_we = 0; bus.id_mem_read = 0; bus.id_ctrl = 0;
    bus.mem_rf_we = 0; bus.mem_rd = 0; bus.mem_wd = 0;
    bus.wb_rf_we = 0; bus.wb_rd = 0; bus.wb_wd = 0;
    bus.hold = 0; bus.flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ld, input logic [31:0] rd0, input logic [31:0] rd1);
    bus.id_valid = 1; bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = 1; bus.id_use_rs2 = !ld; bus.id_mem_read = ld; bus.id_rf_we = 1;
    bus.id_rf_rd0 = rd0; bus.id_rf_rd1 = rd1;
    bus.id_pc = 32'h100 + 32'(rd); bus.id_inst = {27'd0, rd}; bus.id_imm = 32'(rs1);
    bus.id_ctrl = 16'h5A00 | 16'(rd);
  endtask

  task automatic random_inputs();
    bus.id_valid    = ($urandom_range(0, 9) != 0);
    bus.id_pc       = $urandom;
    bus.id_inst     = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs1      = 5'($urandom_range(0, 7));
    bus.id_rs2      = 5'($urandom_range(0, 7));
    bus.id_rd       = 5'($urandom_range(0, 7));
    bus.id_use_rs1  = 1'($urandom_range(0, 1));
    bus.id_use_rs2  = 1'($urandom_range(0, 1));
    bus.id_rf_rd0   = $urandom;
    bus.id_rf_rd1   = $urandom;
    bus.id_rf_we    = 1'($urandom_range(0, 1));
    bus.id_mem_read = ($urandom_range(0, 2) == 0);
    bus.id_ctrl     = 16'($urandom);
    bus.mem_rf_we   = 1'($urandom_range(0, 1));
    bus.mem_rd      = 5'($urandom_range(0, 7));
    bus.mem_wd      = $urandom;
    bus.wb_rf_we    = 1'($urandom_range(0, 1));
    bus.wb_rd       = 5'($urandom_range(0, 7));
    bus.wb_wd       = $urandom;
    bus.hold        = ($urandom_range(0, 6) == 0);
    bus.flush       = ($urandom_range(0, 9) == 0);
    rst             = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    idle_inputs();
    kill_slot();
    m_pc = 0; m_inst = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_rd0 = 0; m_rd1 = 0; m_bub = 0;
    @(negedge clk);

    // Reset state
    rst = 1; cyc();
    rst = 0;
    chk("rst ex_valid", 32'(bus.ex_valid), 0);
    chk("rst ex_pc", bus.ex_pc, 0);
    chk("rst ex_inst", bus.ex_inst, 0);
    chk("rst ex_imm", bus.ex_imm, 0);
    chk("rst ex_rd", 32'(bus.ex_rd), 0);
    chk("rst ex_ctrl", 32'(bus.ex_ctrl), 0);
    chk("rst ex_op1", bus.ex_op1, 0);
    chk("rst bubble_cnt", bus.bubble_cnt, 0);

    // Plain capture
    issue(5'd9, 5'd5, 5'd6, 1'b0, 32'h11, 32'h22); cyc();
    idle_inputs(); #1;
    chk("cap ex_valid", 32'(bus.ex_valid), 1);
    chk("cap ex_op1", bus.ex_op1, 32'h11);
    chk("cap ex_op2", bus.ex_op2, 32'h22);
    chk("cap ex_rf_we", 32'(bus.ex_rf_we), 1);

    // Forward priority MEM over WB, evaluated while held
    issue(5'd10, 5'd3, 5'd4, 1'b0, 32'h33, 32'h44); cyc();
    idle_inputs(); bus.hold = 1;
    bus.mem_rf_we = 1; bus.mem_rd = 3; bus.mem_wd = 32'hAAAA;
    bus.wb_rf_we = 1; bus.wb_rd = 3; bus.wb_wd = 32'hBBBB; #1;
    chk("fwd mem", bus.ex_op1, 32'hAAAA);
    chk("hold stall", 32'(bus.id_stall), 1);
    cyc();
    bus.mem_rf_we = 0; #1;
    chk("fwd wb", bus.ex_op1, 32'hBBBB);
    bus.wb_rf_we = 0; #1;
    chk("fwd none", bus.ex_op1, 32'h33);
    cyc();

    // Load-use: lw x7 then add x8,x7,x1
    idle_inputs();
    issue(5'd7, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0); cyc();
    issue(5'd8, 5'd7, 5'd1, 1'b0, 32'h77, 32'h1); #1;
    chk("lu stall", 32'(bus.id_stall), 1);
    cyc();
    chk("lu bubble valid", 32'(bus.ex_valid), 0);
    chk("lu bubble_cnt", bus.bubble_cnt, 1);
    chk("lu stall released", 32'(bus.id_stall), 0);
    cyc();
    chk("lu add valid", 32'(bus.ex_valid), 1);
    chk("lu add rd", 32'(bus.ex_rd), 8);
    chk("lu bubble_cnt once", bus.bubble_cnt, 1);

    // x0 is never a hazard nor a forwarding source
    issue(5'd0, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0); cyc();
    issue(5'd8, 5'd0, 5'd0, 1'b0, 32'h55, 32'h66); #1;
    chk("x0 no stall", 32'(bus.id_stall), 0);
    chk("x0 lw rf_we", 32'(bus.ex_rf_we), 0);
    bus.mem_rf_we = 1; bus.mem_rd = 0; bus.mem_wd = 32'hDEAD;
    bus.wb_rf_we = 1; bus.wb_rd = 0; bus.wb_wd = 32'hBEEF;
    cyc();
    chk("x0 no fwd op1", bus.ex_op1, 32'h55);
    chk("x0 no fwd op2", bus.ex_op2, 32'h66);

    // Flush beats hazard and hold
    idle_inputs();
    issue(5'd7, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0); cyc();
    issue(5'd8, 5'd7, 5'd1, 1'b0, 32'h0, 32'h0);
    bus.flush = 1; bus.hold = 1; #1;
    chk("flush stall", 32'(bus.id_stall), 1);
    cyc();
    chk("flush valid", 32'(bus.ex_valid), 0);
    chk("flush mem_read", 32'(bus.ex_mem_read), 0);
    chk("flush bubble_cnt", bus.bubble_cnt, 1);

    // Reset in the middle of a hold
    idle_inputs();
    issue(5'd5, 5'd1, 5'd2, 1'b0, 32'h9, 32'h8); cyc();
    bus.hold = 1; rst = 1; cyc();
    rst = 0; bus.hold = 0; idle_inputs(); #1;
    chk("rsthold ex_valid", 32'(bus.ex_valid), 0);
    chk("rsthold ex_pc", bus.ex_pc, 0);
    chk("rsthold bubble_cnt", bus.bubble_cnt, 0);
    chk("rsthold stall", 32'(bus.id_stall), 0);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cyc();
    end
    rst = 0; idle_inputs(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
